dff_bank_arbiter: RTL and testbench

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

---
 rtl/dff_bank_arbiter.sv | 121 ++++++++++++
 tb/tb_dff_bank_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter that lets N requesters take turns
// writing one shared WIDTH-bit flip-flop bank.
// A grant lasts one cycle, the winner's slot is captured at its closing edge,
// and the grant is held until the winner drops req.
// Optional macro DFF_BANK_ARBITER_RACE_CHECK_EN adds a checker that flags the
// winner's data changing between grant and capture (sticky race_err).
//
// state   | meaning
// IDLE    | no grant; pick the next winner from ptr when any req is set
// GRANT   | one cycle; the winner's slot is written to dout at its closing edge
// RELEASE | gnt held until the winner drops req, then ptr moves past it
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               race_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   ptr_next;
  logic            sel_found;
  logic [WIDTH-1:0] slot [N];

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot[i] = din[i*WIDTH +: WIDTH];
  end

  // First set req bit searching upward from ptr, wrapping N-1 -> 0
  always_comb begin
    int idx;
    idx       = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
  end

  assign ptr_next = (win_idx == PW'(N-1)) ? '0 : win_idx + PW'(1);
  assign busy     = (state != IDLE);

  // Grant sequencing, bank capture and round-robin pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ptr        <= '0;
      win_idx    <= '0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt     <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
            win_idx <= sel_idx;
            state   <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          // Capture happens even if the winner already dropped req
          dout       <= slot[win_idx];
          dout_valid <= 1'b1;
          state      <= RELEASE;
        end
        RELEASE: begin
          if (!req[win_idx]) begin
            gnt   <= '0;
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DFF_BANK_ARBITER_RACE_CHECK_EN
  logic [WIDTH-1:0] latched_slot;

  // Latch the winner's slot at grant and compare with what gets captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latched_slot <= '0;
      race_err     <= 1'b0;
    end else begin
      if (state == IDLE && sel_found) latched_slot <= slot[sel_idx];
      if (state == GRANT && slot[win_idx] != latched_slot) race_err <= 1'b1;
    end
  end
`else
  assign race_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed scenarios plus a
// randomized run against a round-robin reference model.
module tb_dff_bank_arbiter;

  localparam int W = 8;
  localparam int N = 4;

`ifdef DFF_BANK_ARBITER_RACE_CHECK_EN
  localparam logic RACE_EXP = 1'b1;
`else
  localparam logic RACE_EXP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           busy;
  logic           race_err;

  int n_cmp = 0;
  int n_err = 0;

  dff_bank_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .race_err(race_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before the summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    din   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int pick(int p, logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    din   = '0;
    #2;
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (race_err !== 1'b0) begin n_err++; $display("FAIL reset_race: got %b want 0", race_err); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    din = {8'h01, 8'hA5, 8'h02, 8'h03};
    req = 4'b0100;
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", dout_valid); end
    step();
    n_cmp++; if (dout !== 8'hA5) begin n_err++; $display("FAIL single_dout: got %h want a5", dout); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", dout_valid); end
    req = '0;
    step();
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL single_release: got %b want 0", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    n_cmp++; if (dout !== 8'hA5 || dout_valid !== 1'b0) begin n_err++; $display("FAIL single_hold: got %h/%b want a5/0", dout, dout_valid); end
  endtask

  task automatic test_all_held();
    do_reset();
    din = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      step();
      n_cmp++; if (gnt !== onehot(i)) begin n_err++; $display("FAIL all_gnt%0d: got %b want %b", i, gnt, onehot(i)); end
      step();
      n_cmp++; if (dout !== din[i*W +: W] || dout_valid !== 1'b1) begin n_err++; $display("FAIL all_dout%0d: got %h/%b want %h/1", i, dout, dout_valid, din[i*W +: W]); end
      req[i] = 1'b0;
      step();
      n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL all_release%0d: got %b want 0", i, gnt); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b0100;
    step();
    step();
    req = '0;
    step();
    req = 4'b1001;
    step();
    n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b want 1000", gnt); end
    step();
    n_cmp++; if (dout !== 8'hD3) begin n_err++; $display("FAIL wrap_dout: got %h want d3", dout); end
    req = 4'b0001;
    step();
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_second: got %b want 0001", gnt); end
    step();
    n_cmp++; if (dout !== 8'hA0) begin n_err++; $display("FAIL wrap_dout2: got %h want a0", dout); end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    din = {8'h00, 8'h00, 8'h5A, 8'h00};
    req = 4'b0010;
    step();
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rmid_pre: got %b want 0010", gnt); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (gnt !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_async: got gnt %b busy %b want 0/0", gnt, busy); end
    n_cmp++; if (dout !== '0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL rmid_dout: got %h/%b want 0/0", dout, dout_valid); end
    #1 reset = 1'b0;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rmid_regrant: got %b want 0010", gnt); end
    step();
    n_cmp++; if (dout !== 8'h5A) begin n_err++; $display("FAIL rmid_dout2: got %h want 5a", dout); end
    req = '0;
    step();
    // Reset during GRANT must abort without capturing
    do_reset();
    din = {8'h00, 8'h00, 8'h00, 8'h77};
    req = 4'b0001;
    step();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    req = '0;
    step();
    n_cmp++; if (dout !== '0 || dout_valid !== 1'b0 || gnt !== '0) begin n_err++; $display("FAIL rgrant_abort: got %h/%b/%b want 0/0/0", dout, dout_valid, gnt); end
  endtask

  task automatic test_drop_in_grant();
    do_reset();
    din = {8'h00, 8'hC3, 8'h00, 8'h00};
    req = 4'b0100;
    step();
    req = '0;
    step();
    n_cmp++; if (dout !== 8'hC3 || dout_valid !== 1'b1) begin n_err++; $display("FAIL drop_capture: got %h/%b want c3/1", dout, dout_valid); end
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL drop_gnt_held: got %b want 0100", gnt); end
    step();
    n_cmp++; if (gnt !== '0 || busy !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL drop_release: got %b/%b/%b want 0/0/0", gnt, busy, dout_valid); end
    step();
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL drop_double_valid: got %b want 0", dout_valid); end
  endtask

  task automatic test_race();
    do_reset();
    din = {8'h00, 8'h00, 8'h11, 8'h00};
    req = 4'b0010;
    step();
    din[1*W +: W] = 8'h22;
    step();
    n_cmp++; if (dout !== 8'h22) begin n_err++; $display("FAIL race_dout: got %h want 22", dout); end
    n_cmp++; if (race_err !== RACE_EXP) begin n_err++; $display("FAIL race_flag: got %b want %b", race_err, RACE_EXP); end
    req = '0;
    step();
    din = {8'h00, 8'h00, 8'h00, 8'h33};
    req = 4'b0001;
    step();
    step();
    req = '0;
    step();
    n_cmp++; if (race_err !== RACE_EXP) begin n_err++; $display("FAIL race_sticky: got %b want %b", race_err, RACE_EXP); end
    reset = 1'b1;
    #1;
    n_cmp++; if (race_err !== 1'b0) begin n_err++; $display("FAIL race_clear: got %b want 0", race_err); end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int mptr;
    int w;
    logic [W-1:0] exp_data;
    logic [N-1:0] wmask;
    do_reset();
    mptr = 0;
    for (int it = 0; it < 200; it++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      din = {$urandom, $urandom};
      w = pick(mptr, req);
      step();
      n_cmp++; if (gnt !== onehot(w) || busy !== 1'b1) begin n_err++; $display("FAIL rnd_gnt it%0d: got %b/%b want %b/1", it, gnt, busy, onehot(w)); end
      wmask    = onehot(w);
      exp_data = din[w*W +: W];
      req = (N'($urandom) & ~wmask) | wmask;
      din = {$urandom, $urandom};
      din[w*W +: W] = exp_data;
      step();
      n_cmp++; if (dout !== exp_data || dout_valid !== 1'b1 || gnt !== wmask) begin n_err++; $display("FAIL rnd_cap it%0d: got %h/%b/%b want %h/1/%b", it, dout, dout_valid, gnt, exp_data, wmask); end
      req = N'($urandom) & ~wmask;
      step();
      n_cmp++; if (gnt !== '0 || busy !== 1'b0 || dout !== exp_data) begin n_err++; $display("FAIL rnd_rel it%0d: got %b/%b/%h want 0/0/%h", it, gnt, busy, dout, exp_data); end
      n_cmp++; if (race_err !== 1'b0) begin n_err++; $display("FAIL rnd_race it%0d: got %b want 0", it, race_err); end
      mptr = (w + 1) % N;
    end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_held();
    test_wrap();
    test_reset_mid();
    test_drop_in_grant();
    test_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
